// File: rtl/mlp_layer_engine_if.sv
// mlp_layer_engine_if: start/finish, input stream, weight/bias ROM ports and result stream of one layer engine.
interface mlp_layer_engine_if #(
  parameter int DATA_W = 16,
  parameter int N_IN = 4,
  parameter int N_OUT = 4
);
  localparam int AW = N_IN * N_OUT > 1 ? $clog2(N_IN * N_OUT) : 1;
  localparam int BW = N_OUT > 1 ? $clog2(N_OUT) : 1;
  logic start, finished;
  logic in_valid, in_ready;
  logic [DATA_W-1:0] in_data;
  logic [AW-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic [BW-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic [DATA_W-1:0] out;
  logic out_valid, out_ready;
  logic [BW-1:0] out_idx;
  modport master (
    input start, in_valid, in_data, w_data, b_data, out_ready,
    output finished, in_ready, w_addr, b_addr, out, out_valid, out_idx
  );
  modport slave (
    output start, in_valid, in_data, w_data, b_data, out_ready,
    input finished, in_ready, w_addr, b_addr, out, out_valid, out_idx
  );
endinterface

// File: rtl/mlp_layer_engine.sv
// mlp_layer_engine: fully-connected layer, one ROM-fed MAC pass per neuron with saturating Q-format output.
// Define MLP_LAYER_RELU_EN to clamp negative results to zero (hidden layers).
module mlp_layer_engine #(
  parameter int DATA_W = 16,
  parameter int FRAC = 8,
  parameter int N_IN = 4,
  parameter int N_OUT = 4,
  parameter int ACC_W = 40
) (
  input logic clk,
  input logic reset,
  mlp_layer_engine_if.master bus
);
  localparam int AW = N_IN * N_OUT > 1 ? $clog2(N_IN * N_OUT) : 1;
  localparam int BW = N_OUT > 1 ? $clog2(N_OUT) : 1;
  localparam int IW = N_IN > 1 ? $clog2(N_IN) : 1;
  localparam int CW = $clog2(N_IN + 2);
  localparam int PW = 2 * DATA_W;
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = ~MAXV;
  typedef enum logic [2:0] {IDLE, LOAD, MAC, OUT, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] k_q, k_d;
  logic [CW-1:0] c_q, c_d;
  logic [BW-1:0] j_q, j_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, sh, bias;
  logic signed [PW-1:0] prod;
  logic [DATA_W-1:0] out_q, out_d, sat, res;
  logic signed [DATA_W-1:0] x_q [2**IW];
  logic last_k, last_j;
  assign last_k = k_q == IW'(N_IN - 1);
  assign last_j = j_q == BW'(N_OUT - 1);
  // ROM data returned in MAC cycle c belongs to the address issued in cycle c-1
  assign prod = PW'(x_q[IW'(c_q - CW'(1))]) * PW'($signed(bus.w_data));
  assign bias = ACC_W'($signed(bus.b_data)) <<< FRAC;
  assign sh = acc_q >>> FRAC;
  assign sat = sh > MAXV ? MAXV[DATA_W-1:0] : sh < MINV ? MINV[DATA_W-1:0] : sh[DATA_W-1:0];
`ifdef MLP_LAYER_RELU_EN
  assign res = sat[DATA_W-1] ? '0 : sat;
`else
  assign res = sat;
`endif
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    c_d = c_q;
    j_d = j_q;
    acc_d = acc_q;
    out_d = out_q;
    case (state_q)
      IDLE, DONE: if (bus.start) begin
        state_d = LOAD;
        k_d = '0;
        j_d = '0;
      end
      LOAD: if (bus.in_valid) begin
        k_d = last_k ? '0 : k_q + 1'b1;
        c_d = '0;
        state_d = last_k ? MAC : LOAD;
      end
      MAC: begin
        c_d = c_q + 1'b1;
        acc_d = c_q == '0 ? '0 :
                c_q == CW'(1) ? bias + ACC_W'(prod) :
                c_q <= CW'(N_IN) ? acc_q + ACC_W'(prod) : acc_q;
        if (c_q == CW'(N_IN + 1)) begin
          out_d = res;
          state_d = OUT;
        end
      end
      OUT: if (bus.out_ready) begin
        state_d = last_j ? DONE : MAC;
        j_d = last_j ? j_q : j_q + 1'b1;
        c_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q <= '0;
      c_q <= '0;
      j_q <= '0;
      acc_q <= '0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      c_q <= c_d;
      j_q <= j_d;
      acc_q <= acc_d;
      out_q <= out_d;
    end
  end
  always_ff @(posedge clk)
    if (!reset && state_q == LOAD && bus.in_valid) x_q[k_q] <= $signed(bus.in_data);
  assign bus.in_ready = state_q == LOAD;
  assign bus.out_valid = state_q == OUT;
  assign bus.finished = state_q == DONE;
  assign bus.out = out_q;
  assign bus.out_idx = j_q;
  assign bus.w_addr = state_q == MAC && c_q < CW'(N_IN) ? AW'(int'(j_q) * N_IN + int'(c_q)) : '0;
  assign bus.b_addr = state_q == MAC ? j_q : '0;
endmodule
